usb_cmd_interpreter: RTL and testbench

Decodes fixed-length 4-word command packets from the host and drives a simple register bus. Packets arrive on the host→FPGA command/status FIFO (the EP4 write side of the USB slave-FIFO interface, read here). A 4-word response goes back on the FPGA→host command/status FIFO (the EP8 read side, written here). It runs in the FIFO clock domain and sits directly downstream/upstream of the USB slave-FIFO interface.

---
 rtl/usb_cmd_pkg.sv | 30 +++
 rtl/usb_cmd_csum.sv | 29 ++
 rtl/usb_cmd_interpreter.sv | 197 +++++++++++++++++++
 tb/tb_usb_cmd_interpreter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cmd_pkg.sv
// usb_cmd_pkg: shared constants and state encoding for the USB command
// interpreter (packet headers, opcodes, response status codes, FSM states).
package usb_cmd_pkg;

    localparam logic [15:0] CMD_HDR = 16'hC3A5;
    localparam logic [15:0] RSP_HDR = 16'h5A3C;

    localparam logic [1:0] OP_PING    = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_READ    = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    localparam logic [15:0] ST_OK    = 16'h0000;
    localparam logic [15:0] ST_CSUM  = 16'h0001;
    localparam logic [15:0] ST_BADOP = 16'h0002;

    typedef enum logic [3:0] {
        S_HDR,
        S_CMD,
        S_DATA,
        S_CSUM,
        S_EXEC,
        S_RDATA,
        S_RSP0,
        S_RSP1,
        S_RSP2,
        S_RSP3
    } state_t;

endpackage

// File: rtl/usb_cmd_csum.sv
// usb_cmd_csum: running 16-bit sum of the command and data words of a packet,
// compared against the packet's checksum word. Only instantiated when
// USB_CMD_CSUM_EN is defined.
module usb_cmd_csum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        add_en,
    input  logic [15:0] add_data,
    input  logic [15:0] csum_word,
    output logic        match
);

    logic [15:0] sum;

    // Accumulate w1 and w2 modulo 2^16; restart while waiting for a header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 16'h0000;
        end else if (clear) begin
            sum <= 16'h0000;
        end else if (add_en) begin
            sum <= sum + add_data;
        end
    end

    assign match = (sum == csum_word);

endmodule

// File: rtl/usb_cmd_interpreter.sv
// usb_cmd_interpreter: reads 4-word command packets from the host command
// FIFO, executes ping/write/read on a simple register bus and returns a
// 4-word response. Define USB_CMD_CSUM_EN to verify the checksum word;
// otherwise the checksum word is read and discarded.
module usb_cmd_interpreter
    import usb_cmd_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          cmd_fifo_data,
    input  logic                 cmd_fifo_empty,
    output logic                 cmd_fifo_re,
    output logic [15:0]          rsp_fifo_data,
    output logic                 rsp_fifo_we,
    input  logic                 rsp_fifo_full,
    output logic [ADDR_W-1:0]    reg_addr,
    output logic [15:0]          reg_wdata,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [15:0]          reg_rdata,
    output logic                 busy,
    output logic [15:0]          pkt_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_t      state;
    state_t      state_next;
    logic        rd_pending;
    logic [15:0] w1_q;
    logic [15:0] w2_q;
    logic [15:0] rsp2_q;
    logic [15:0] status_q;
    logic [15:0] exec_status;
    logic        csum_bad;
    logic        hdr_bad;
    logic [1:0]  op;

    assign op      = w1_q[15:14];
    assign busy    = (state != S_HDR);
    assign hdr_bad = (state == S_HDR) && rd_pending && (cmd_fifo_data != CMD_HDR);

`ifdef USB_CMD_CSUM_EN
    logic [15:0] w3_q;
    logic        csum_match;

    usb_cmd_csum u_csum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == S_HDR),
        .add_en    (rd_pending && ((state == S_CMD) || (state == S_DATA))),
        .add_data  (cmd_fifo_data),
        .csum_word (w3_q),
        .match     (csum_match)
    );

    assign csum_bad = !csum_match;

    // Hold the received checksum word for the comparison in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w3_q <= 16'h0000;
        end else if (rd_pending && (state == S_CSUM)) begin
            w3_q <= cmd_fifo_data;
        end
    end
`else
    assign csum_bad = 1'b0;
`endif

    // Checksum errors take priority over an illegal opcode.
    always_comb begin
        exec_status = ST_OK;
        if (csum_bad) begin
            exec_status = ST_CSUM;
        end else if (op == OP_ILLEGAL) begin
            exec_status = ST_BADOP;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobes: one FIFO read in flight at a time, register
    // strobes only in EXEC, response words held until the FIFO accepts them.
    always_comb begin
        state_next    = state;
        cmd_fifo_re   = 1'b0;
        rsp_fifo_we   = 1'b0;
        rsp_fifo_data = 16'h0000;
        reg_we        = 1'b0;
        reg_re        = 1'b0;
        case (state)
            S_HDR, S_CMD, S_DATA, S_CSUM: begin
                if (rd_pending) begin
                    case (state)
                        S_HDR:   state_next = (cmd_fifo_data == CMD_HDR) ? S_CMD : S_HDR;
                        S_CMD:   state_next = S_DATA;
                        S_DATA:  state_next = S_CSUM;
                        default: state_next = S_EXEC;
                    endcase
                end else begin
                    cmd_fifo_re = !cmd_fifo_empty;
                end
            end
            S_EXEC: begin
                if (exec_status == ST_OK) begin
                    reg_we = (op == OP_WRITE);
                    reg_re = (op == OP_READ);
                end
                state_next = S_RDATA;
            end
            S_RDATA: begin
                state_next = S_RSP0;
            end
            S_RSP0: begin
                rsp_fifo_data = RSP_HDR;
                rsp_fifo_we   = !rsp_fifo_full;
                if (!rsp_fifo_full) state_next = S_RSP1;
            end
            S_RSP1: begin
                rsp_fifo_data = w1_q;
                rsp_fifo_we   = !rsp_fifo_full;
                if (!rsp_fifo_full) state_next = S_RSP2;
            end
            S_RSP2: begin
                rsp_fifo_data = rsp2_q;
                rsp_fifo_we   = !rsp_fifo_full;
                if (!rsp_fifo_full) state_next = S_RSP3;
            end
            S_RSP3: begin
                rsp_fifo_data = status_q;
                rsp_fifo_we   = !rsp_fifo_full;
                if (!rsp_fifo_full) state_next = S_HDR;
            end
            default: begin
                state_next = S_HDR;
            end
        endcase
    end

    // Capture packet words and build the response payload and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            w1_q       <= 16'h0000;
            w2_q       <= 16'h0000;
            rsp2_q     <= 16'h0000;
            status_q   <= ST_OK;
            reg_addr   <= '0;
            reg_wdata  <= 16'h0000;
        end else begin
            rd_pending <= cmd_fifo_re;
            if (rd_pending && (state == S_CMD)) begin
                w1_q     <= cmd_fifo_data;
                reg_addr <= cmd_fifo_data[ADDR_W-1:0];
            end
            if (rd_pending && (state == S_DATA)) begin
                w2_q      <= cmd_fifo_data;
                reg_wdata <= cmd_fifo_data;
            end
            if (state == S_EXEC) begin
                status_q <= exec_status;
                rsp2_q   <= (exec_status == ST_OK) ? w2_q : 16'h0000;
            end
            if ((state == S_RDATA) && (status_q == ST_OK) && (op == OP_READ)) begin
                rsp2_q <= reg_rdata;
            end
        end
    end

    // Packet counter wraps; error counter saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= 16'h0000;
            err_count <= '0;
        end else begin
            if ((state == S_EXEC) && (exec_status == ST_OK)) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (hdr_bad || ((state == S_EXEC) && (exec_status != ST_OK))) begin
                if (err_count != {ERR_CNT_W{1'b1}}) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_cmd_interpreter.sv
// tb_usb_cmd_interpreter: directed self-checking bench. A behavioural model
// pushes expected response words and register strobes into scoreboards when
// a packet is queued; negedge monitors pop and compare when the DUT emits them.
module tb_usb_cmd_interpreter;

    localparam logic [15:0] RDATA = 16'h1234;

    typedef struct packed {
        logic        is_write;
        logic [7:0]  addr;
        logic [15:0] data;
    } reg_ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd_fifo_data = 16'h0000;
    logic        cmd_fifo_empty = 1'b1;
    logic        cmd_fifo_re;
    logic [15:0] rsp_fifo_data;
    logic        rsp_fifo_we;
    logic        rsp_fifo_full = 1'b0;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata = 16'h0000;
    logic        busy;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_pkt = 0;
    int exp_err = 0;

    logic [15:0] cmd_q[$];
    logic [15:0] exp_rsp_q[$];
    reg_ev_t     exp_reg_q[$];
    int          rsp_cycles[$];
    int          reg_cycles[$];

    usb_cmd_interpreter #(.ADDR_W(8), .ERR_CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_fifo_data  (cmd_fifo_data),
        .cmd_fifo_empty (cmd_fifo_empty),
        .cmd_fifo_re    (cmd_fifo_re),
        .rsp_fifo_data  (rsp_fifo_data),
        .rsp_fifo_we    (rsp_fifo_we),
        .rsp_fifo_full  (rsp_fifo_full),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_we         (reg_we),
        .reg_re         (reg_re),
        .reg_rdata      (reg_rdata),
        .busy           (busy),
        .pkt_count      (pkt_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Command FIFO model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (cmd_fifo_re && (cmd_q.size() != 0)) begin
            cmd_fifo_data <= cmd_q.pop_front();
        end
        cmd_fifo_empty <= (cmd_q.size() == 0);
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Monitor FIFO strobes and compare response words against the scoreboard.
    always @(negedge clk) begin
        if (cmd_fifo_re) check_output("re_while_empty", {31'd0, cmd_fifo_empty}, 32'd0);
        if (rsp_fifo_we) begin
            check_output("we_while_full", {31'd0, rsp_fifo_full}, 32'd0);
            checks++;
            assert (exp_rsp_q.size() != 0) else begin
                errors++;
                $error("[TB] FAIL rsp_extra: observed=%0h expected=none", rsp_fifo_data);
            end
            if (exp_rsp_q.size() != 0) check_output("rsp_word", {16'd0, rsp_fifo_data}, {16'd0, exp_rsp_q.pop_front()});
            rsp_cycles.push_back(cyc);
        end
    end

    // Monitor register strobes against the expected register events.
    always @(negedge clk) begin
        if (reg_we || reg_re) begin
            reg_ev_t ev;
            checks++;
            assert (exp_reg_q.size() != 0) else begin
                errors++;
                $error("[TB] FAIL reg_extra: observed we=%0b re=%0b addr=%0h expected=none", reg_we, reg_re, reg_addr);
            end
            if (exp_reg_q.size() != 0) begin
                ev = exp_reg_q.pop_front();
                check_output("reg_we_kind", {31'd0, reg_we}, {31'd0, ev.is_write});
                check_output("reg_re_kind", {31'd0, reg_re}, {31'd0, !ev.is_write});
                check_output("reg_addr", {24'd0, reg_addr}, {24'd0, ev.addr});
                if (ev.is_write) check_output("reg_wdata", {16'd0, reg_wdata}, {16'd0, ev.data});
            end
            reg_cycles.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue one packet and record what the DUT should do with it.
    task automatic apply_stimulus(input logic [15:0] w0, input logic [15:0] w1,
                                  input logic [15:0] w2, input logic [15:0] w3, input int gap);
        logic [15:0] sum;
        logic        csum_ok;
        logic [15:0] r2;
        logic [15:0] st;
        sum = w1 + w2;
`ifdef USB_CMD_CSUM_EN
        csum_ok = (sum == w3);
`else
        csum_ok = 1'b1;
`endif
        if (!csum_ok) begin
            st = 16'h0001;
            r2 = 16'h0000;
        end else if (w1[15:14] == 2'd3) begin
            st = 16'h0002;
            r2 = 16'h0000;
        end else begin
            st = 16'h0000;
            r2 = (w1[15:14] == 2'd2) ? RDATA : w2;
        end
        if (st == 16'h0000) begin
            exp_pkt++;
            if (w1[15:14] == 2'd1) exp_reg_q.push_back('{1'b1, w1[7:0], w2});
            if (w1[15:14] == 2'd2) exp_reg_q.push_back('{1'b0, w1[7:0], 16'h0000});
        end else begin
            exp_err++;
        end
        exp_rsp_q.push_back(16'h5A3C);
        exp_rsp_q.push_back(w1);
        exp_rsp_q.push_back(r2);
        exp_rsp_q.push_back(st);
        cmd_q.push_back(w0);
        if (gap > 0) tick(gap);
        cmd_q.push_back(w1);
        if (gap > 0) tick(gap);
        cmd_q.push_back(w2);
        if (gap > 0) tick(gap);
        cmd_q.push_back(w3);
    endtask

    // Wait for the response to drain, then compare counters and scoreboards.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (((exp_rsp_q.size() != 0) || busy || (cmd_q.size() != 0)) && (n < 300)) begin
            tick(1);
            n++;
        end
        check_output({tag, "_timeout"}, {31'd0, (n < 300)}, 32'd1);
        tick(1);
        check_output({tag, "_pkt_count"}, {16'd0, pkt_count}, exp_pkt);
        check_output({tag, "_err_count"}, {24'd0, err_count}, exp_err);
        check_output({tag, "_reg_pending"}, exp_reg_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int base_rsp;
        int base_reg;
        int n;

        reg_rdata = RDATA;
        rst_n = 1'b0;
        tick(3);
        // Reset state
        check_output("rst_cmd_re", {31'd0, cmd_fifo_re}, 32'd0);
        check_output("rst_rsp_we", {31'd0, rsp_fifo_we}, 32'd0);
        check_output("rst_reg_we", {31'd0, reg_we}, 32'd0);
        check_output("rst_reg_re", {31'd0, reg_re}, 32'd0);
        check_output("rst_rsp_data", {16'd0, rsp_fifo_data}, 32'd0);
        check_output("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
        check_output("rst_reg_wdata", {16'd0, reg_wdata}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check_output("rst_err_count", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Write with cycle-exact latency
        $display("[TB] write packet");
        base_rsp = rsp_cycles.size();
        base_reg = reg_cycles.size();
        apply_stimulus(16'hC3A5, 16'h4012, 16'hBEEF, 16'hFF01, 0);
        n = 0;
        while (cmd_fifo_empty && (n < 10)) begin
            tick(1);
            n++;
        end
        t0 = cyc;
        wait_done("write");
        check_output("write_reg_we_cycle", (reg_cycles.size() > base_reg) ? reg_cycles[base_reg] - t0 : -1, 32'd8);
        check_output("write_rsp0_cycle", (rsp_cycles.size() > base_rsp) ? rsp_cycles[base_rsp] - t0 : -1, 32'd10);
        check_output("write_rsp3_cycle", (rsp_cycles.size() > base_rsp + 3) ? rsp_cycles[base_rsp + 3] - t0 : -1, 32'd13);
        check_output("write_hold_addr", {24'd0, reg_addr}, 32'h12);
        check_output("write_hold_wdata", {16'd0, reg_wdata}, 32'hBEEF);

        // Read
        $display("[TB] read packet");
        apply_stimulus(16'hC3A5, 16'h8034, 16'h0000, 16'h8034, 0);
        wait_done("read");

        // Bad checksum (executes as a write when checking is compiled out)
        $display("[TB] bad checksum packet");
        apply_stimulus(16'hC3A5, 16'h4012, 16'hBEEF, 16'h0000, 0);
        wait_done("badcsum");

        // Illegal opcode
        $display("[TB] illegal opcode packet");
        apply_stimulus(16'hC3A5, 16'hC012, 16'h0000, 16'hC012, 0);
        wait_done("badop");

        // Resync after junk words, then a ping
        $display("[TB] resync");
        cmd_q.push_back(16'h1111);
        cmd_q.push_back(16'h2222);
        exp_err += 2;
        apply_stimulus(16'hC3A5, 16'h0000, 16'h0000, 16'h0000, 0);
        wait_done("resync");

        // Empty gaps between words and full backpressure in RSP1
        $display("[TB] stall and backpressure");
        base_rsp = rsp_cycles.size();
        apply_stimulus(16'hC3A5, 16'h4077, 16'h0102, 16'h4179, 3);
        n = 0;
        while ((rsp_cycles.size() < base_rsp + 1) && (n < 200)) begin
            tick(1);
            n++;
        end
        rsp_fifo_full = 1'b1;
        tick(5);
        rsp_fifo_full = 1'b0;
        wait_done("stall");
        check_output("stall_rsp1_gap", (rsp_cycles.size() > base_rsp + 1) ? rsp_cycles[base_rsp + 1] - rsp_cycles[base_rsp] : -1, 32'd6);

        // Reset while waiting in DATA, then a fresh write
        $display("[TB] reset mid-packet");
        cmd_q.push_back(16'hC3A5);
        cmd_q.push_back(16'h4012);
        tick(8);
        check_output("midpkt_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick(2);
        check_output("midrst_busy", {31'd0, busy}, 32'd0);
        check_output("midrst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check_output("midrst_err_count", {24'd0, err_count}, 32'd0);
        check_output("midrst_reg_addr", {24'd0, reg_addr}, 32'd0);
        exp_pkt = 0;
        exp_err = 0;
        rst_n = 1'b1;
        tick(2);
        apply_stimulus(16'hC3A5, 16'h4055, 16'h1111, 16'h5166, 0);
        wait_done("postrst");
        check_output("postrst_addr", {24'd0, reg_addr}, 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
